// File: rtl/add_pkg.sv
// Shared types for the round-robin adder sequencer: datapath widths,
// FSM encoding and the latched operand record.
package add_pkg;

    localparam int ADD_W = 64;
    localparam int BLK_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
        logic             cin;
    } add_op_t;

endpackage

// File: rtl/add_csel64.sv
// Carry-select adder, 8-bit blocks: each block precomputes both carry-in
// cases and the ripple of block carries picks one.
module add_csel64
    import add_pkg::*;
#(
    parameter int W  = ADD_W,
    parameter int BW = BLK_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int NB = W / BW;

    logic [NB:0]        c;
    logic [NB-1:0][BW:0] s0;
    logic [NB-1:0][BW:0] s1;

    assign c[0] = cin;

    for (genvar i = 0; i < NB; i++) begin : g_blk
        assign s0[i] = {1'b0, a[i*BW +: BW]} + {1'b0, b[i*BW +: BW]};
        assign s1[i] = {1'b0, a[i*BW +: BW]} + {1'b0, b[i*BW +: BW]} + (BW+1)'(1);
        assign sum[i*BW +: BW] = c[i] ? s1[i][BW-1:0] : s0[i][BW-1:0];
        assign c[i+1]          = c[i] ? s1[i][BW]     : s0[i][BW];
    end

    assign cout = c[NB];

endmodule

// File: rtl/add_rr_arb.sv
// Combinational round-robin grant: first valid requester at or after rr_ptr,
// wrapping modulo NREQ. Produces a one-hot grant and its index.
module add_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_valid
);

    int             pos;
    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Candidate position k steps after the pointer, wrapped.
            pos = (int'(rr_ptr) + k) % NREQ;
            idx = IDW'(pos);
            if (!any_valid && req_valid[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/add_rr_arbiter.sv
// Shares one carry-select adder among NREQ requesters: round-robin accept,
// one registered add, tagged response held until consumed.
module add_rr_arbiter
    import add_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][ADD_W-1:0]  req_a,
    input  logic [NREQ-1:0][ADD_W-1:0]  req_b,
    input  logic [NREQ-1:0]             req_cin,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic [ADD_W-1:0]            rsp_sum,
    output logic                        rsp_cout,
    output logic                        busy,
    output logic [CNT_W-1:0]            op_count
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    add_op_t          op_q, op_d;
    logic [IDW-1:0]   op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [ADD_W-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             any_valid;
    logic             accept_ok;
    logic             xfer;
    logic             rsp_hs;
    logic [ADD_W-1:0] sum_w;
    logic             cout_w;

    add_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    add_csel64 u_add (
        .a    (op_q.a),
        .b    (op_q.b),
        .cin  (op_q.cin),
        .sum  (sum_w),
        .cout (cout_w)
    );

    // A slot opens when idle, or when the held response drains this cycle.
    assign accept_ok = (state_q == IDLE) || (state_q == RESP && rsp_ready);
    assign xfer      = accept_ok && any_valid;
    assign rsp_hs    = rsp_valid_q && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = CALC;
            CALC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = xfer ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = accept_ok ? grant : '0;
        busy        = (state_q == CALC) || (state_q == RESP);

        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        op_count_d  = op_count_q;

        if (xfer) begin
            op_d.a   = req_a[grant_idx];
            op_d.b   = req_b[grant_idx];
            op_d.cin = req_cin[grant_idx];
            op_id_d  = grant_idx;
            rr_ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end

        if (state_q == CALC) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = op_id_q;
            rsp_sum_d   = sum_w;
            rsp_cout_d  = cout_w;
        end else if (state_q == RESP && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (rsp_hs && op_count_q != '1)
            op_count_d = op_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            op_q        <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_add_rr_arbiter.sv
// Directed bench for add_rr_arbiter; a second instance with a 2-bit counter
// runs in lockstep to exercise counter saturation.
module tb_add_rr_arbiter;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]       req_valid, req_cin, req_ready, s_req_ready;
    logic [NREQ-1:0][63:0] req_a, req_b;
    logic                  rsp_ready;
    logic                  rsp_valid, rsp_cout, busy;
    logic [1:0]            rsp_id;
    logic [63:0]           rsp_sum;
    logic [31:0]           op_count;
    logic                  s_rsp_valid, s_rsp_cout, s_busy;
    logic [1:0]            s_rsp_id;
    logic [63:0]           s_rsp_sum;
    logic [1:0]            s_op_count;

    add_rr_arbiter #(.NREQ(NREQ), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy), .op_count(op_count)
    );

    add_rr_arbiter #(.NREQ(NREQ), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_sum(s_rsp_sum), .rsp_cout(s_rsp_cout), .busy(s_busy), .op_count(s_op_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Per-requester operands with hand-computed results.
    logic [63:0] exp_sum  [NREQ];
    logic        exp_cout [NREQ];
    int          gseq     [6];

    initial begin
        req_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; req_b[0] = 64'h1;    req_cin[0] = 1'b0;
        req_a[1] = 64'h0000_0000_FFFF_FFFF; req_b[1] = 64'h1;    req_cin[1] = 1'b0;
        req_a[2] = 64'h1234;                req_b[2] = 64'h0F0F; req_cin[2] = 1'b1;
        req_a[3] = 64'h8000_0000_0000_0000; req_b[3] = 64'h8000_0000_0000_0000; req_cin[3] = 1'b1;
        exp_sum[0] = 64'h0;             exp_cout[0] = 1'b1;
        exp_sum[1] = 64'h1_0000_0000;   exp_cout[1] = 1'b0;
        exp_sum[2] = 64'h2144;          exp_cout[2] = 1'b0;
        exp_sum[3] = 64'h1;             exp_cout[3] = 1'b1;
        gseq = '{0, 1, 2, 3, 0, 1};
        req_valid = '0;
        rsp_ready = 1'b0;

        // 1. reset values, then a single request from requester 0
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_op_count",  64'(op_count),  64'd0);
        chk("rst_rsp_sum",   rsp_sum,        64'd0);
        chk("rst_rsp_id",    64'(rsp_id),    64'd0);
        chk("rst_rsp_cout",  64'(rsp_cout),  64'd0);
        rst = 1'b0;
        req_valid = 4'b0001;
        #1 chk("t1_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = '0;
        chk("t1_calc_busy",  64'(busy),      64'd1);
        chk("t1_calc_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid", 64'(rsp_valid), 64'd1);
        chk("t1_sum",   rsp_sum,        64'd0);
        chk("t1_cout",  64'(rsp_cout),  64'd1);
        chk("t1_id",    64'(rsp_id),    64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t1_done_valid", 64'(rsp_valid), 64'd0);
        chk("t1_done_busy",  64'(busy),      64'd0);
        chk("t1_op_count",   64'(op_count),  64'd1);

        // 2. all requesters valid: grants 0,1,2,3,0, one response per 2 cycles
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1111;
        #1 chk("t2_ready_k0", 64'(req_ready), 64'b0001);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("t2_valid_k%0d", k), 64'(rsp_valid), 64'((k >= 2) && (k % 2 == 0)));
            if (k % 2 == 0) begin
                chk($sformatf("t2_id_k%0d", k),  64'(rsp_id),   64'(gseq[k/2-1]));
                chk($sformatf("t2_sum_k%0d", k), rsp_sum,       exp_sum[gseq[k/2-1]]);
                chk($sformatf("t2_ready_k%0d", k), 64'(req_ready), 64'(4'b0001 << gseq[k/2]));
            end else begin
                chk($sformatf("t2_ready_k%0d", k), 64'(req_ready), 64'd0);
            end
            if (k == 6) begin
                chk("t2_cnt_2",     64'(op_count),   64'd2);
                chk("t2_sat_cnt_2", 64'(s_op_count), 64'd2);
            end
            if (k == 10) begin
                chk("t2_cnt_4",     64'(op_count),   64'd4);
                chk("t2_sat_cnt_4", 64'(s_op_count), 64'd3);
            end
        end
        req_valid = '0;
        @(negedge clk);
        chk("t2_op_count", 64'(op_count),   64'd5);
        chk("t2_sat_hold", 64'(s_op_count), 64'd3);
        chk("t2_idle",     64'(busy),       64'd0);

        // 3. backpressure on requester 2's response
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        #1 chk("t3_ready", 64'(req_ready), 64'b0100);
        @(negedge clk);
        req_valid = 4'b1011;
        #1 chk("t3_calc_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            chk($sformatf("t3_valid_%0d", j), 64'(rsp_valid), 64'd1);
            chk($sformatf("t3_sum_%0d", j),   rsp_sum,        64'h2144);
            chk($sformatf("t3_id_%0d", j),    64'(rsp_id),    64'd2);
            chk($sformatf("t3_ready_%0d", j), 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1 chk("t3_b2b_ready", 64'(req_ready), 64'b1000);
        @(negedge clk);
        req_valid = '0;
        chk("t3_b2b_calc_valid", 64'(rsp_valid), 64'd0);
        chk("t3_op_count",       64'(op_count),  64'd6);

        // 5a. 0x8000.. + 0x8000.. + 1 via requester 3
        @(negedge clk);
        chk("t5a_valid", 64'(rsp_valid), 64'd1);
        chk("t5a_id",    64'(rsp_id),    64'd3);
        chk("t5a_sum",   rsp_sum,        64'd1);
        chk("t5a_cout",  64'(rsp_cout),  64'd1);

        // 4. reset while in CALC
        @(negedge clk);
        chk("t4_pre_valid", 64'(rsp_valid), 64'd0);
        chk("t4_pre_cnt",   64'(op_count),  64'd7);
        req_valid = 4'b0100;
        #1 chk("t4_ready", 64'(req_ready), 64'b0100);
        @(negedge clk);
        chk("t4_calc_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_rst_valid", 64'(rsp_valid), 64'd0);
        chk("t4_rst_busy",  64'(busy),      64'd0);
        chk("t4_rst_cnt",   64'(op_count),  64'd0);
        req_a[0] = 64'd0; req_b[0] = 64'd0; req_cin[0] = 1'b0;
        req_valid = 4'b1111;
        #1 chk("t4_ptr_reset_grant", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = '0;
        chk("t4_no_stale_rsp", 64'(rsp_valid), 64'd0);

        // 5b. zero operands
        @(negedge clk);
        chk("t5b_valid", 64'(rsp_valid), 64'd1);
        chk("t5b_id",    64'(rsp_id),    64'd0);
        chk("t5b_sum",   rsp_sum,        64'd0);
        chk("t5b_cout",  64'(rsp_cout),  64'd0);
        @(negedge clk);
        chk("t5b_op_count", 64'(op_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
